kernel_b_stream_feeder: RTL and testbench
=========================================

Name: kernel_B_stream_feeder

Overview:
- Upstream stage that feeds the kernel_B top-level compute block.
- Accepts a valid/ready input stream and buffers it in a small FIFO.
- Drives the kernel's data input and its single `stall` control, asserting `stall` whenever no data is available or the downstream sink back-pressures.
- Counts exactly NKI work-items per run and reports completion, so the stall-driven kernel pipeline never consumes an invalid word.

Parameters:
- DATAW, 32, data word width; matches the kernel's DATAW.
- FIFO_DEPTH, 4, buffer entries; must be a power of 2 and at least 2.
- NKI, 1024, work-items per run (kernel iterations).
- CNTW, 16, item-counter width; must satisfy 2^CNTW > NKI.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a run, honoured only in IDLE
- src_data  in  DATAW  input stream word
- src_valid  in  1  src_data valid
- src_ready  out  1  feeder accepts src_data this cycle
- dst_stall  in  1  downstream sink cannot take a kernel result this cycle
- krn_data  out  DATAW  word to the kernel data input (kb_vin)
- krn_stall  out  1  stall to the kernel; high means the kernel holds
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the NKI-th item is issued

Behaviour:
- Reset (synchronous, active-high), applied at any time including mid-run:
  - state goes to IDLE; FIFO is emptied; both counters are cleared.
  - Outputs: src_ready=0, krn_stall=1, krn_data=0, busy=0, done=0.
- FSM:
  - IDLE -> RUN on start. Entering RUN clears acc_cnt and iss_cnt.
  - RUN -> DONE in the cycle that the issue making iss_cnt==NKI occurs.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only while in DONE.
  - start is ignored outside IDLE.
- Accept:
  - src_ready = RUN & !full & (acc_cnt < NKI). This is combinational.
  - A push happens when src_valid & src_ready; acc_cnt increments by 1 on each push.
  - Input words beyond NKI are never accepted.
- Issue:
  - krn_stall = !(RUN & !empty & !dst_stall). This is combinational.
  - When krn_stall=0, the FIFO head is presented on krn_data, popped, and iss_cnt increments.
  - krn_data is a registered copy of the FIFO head. It updates on pop (next head) and on push-into-empty. It holds its value while stalled.
- Latency: a word pushed at cycle t appears on krn_data with krn_stall=0 at cycle t+1 at the earliest (FIFO empty, dst_stall=0).
- Throughput: 1 word/cycle sustained when src_valid=1 and dst_stall=0.
- Simultaneous push and pop:
  - Allowed when the FIFO is neither empty nor full; occupancy is unchanged.
  - When full, push is blocked by src_ready=0; a pop still proceeds, and a push is possible next cycle.
  - When empty, there is no pop; the push lands and is issued next cycle.
- Pointers: CLOG2(FIFO_DEPTH)+1 bits each, wrapping modulo 2*FIFO_DEPTH.
  - full: MSBs differ, low bits equal.
  - empty: pointers equal.
- Ordering: words are issued in arrival order; no word is dropped or duplicated.
- Counters: saturate at NKI; they never wrap within a run.

Decomposition:
- Shared package holds:
  - DATAW default
  - CLOG2 function
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
- One natural sub-module: kernel_B_sync_fifo.
  - Parameterised on DATAW and FIFO_DEPTH, with synchronous rst.
  - Ports: push, pop, din, dout, full, empty.
- The feeder instantiates this FIFO and adds the FSM, counters and stall/ready logic.

Test Plan:
- Reset mid-run: after 5 pushes, pulse rst -> next cycle krn_stall=1, src_ready=0, krn_data=0, busy=0; a subsequent run with start processes all NKI items from count 0.
- Streaming, NKI=8, src_valid=1 continuously, data 1..8, dst_stall=0 -> start at t0; krn_data=1..8 on consecutive cycles with krn_stall=0; done pulses exactly once; busy falls with done.
- Back-pressure: dst_stall=1 for 6 cycles mid-run with FIFO_DEPTH=4 -> FIFO fills, src_ready=0 after 4 pushes, krn_data held constant; on release the order is preserved with no loss.
- Starved source: src_valid toggling 1,0,0,1 -> krn_stall=1 whenever the FIFO is empty; issued sequence equals accepted sequence.
- Overrun guard: source keeps src_valid=1 after NKI words -> src_ready=0 once acc_cnt=NKI; the 9th word is not accepted.
- start during RUN, and start asserted together with rst -> ignored; no counter clear; rst wins.

Source files
------------

// File: rtl/kernel_b_stream_feeder_pkg.sv
// Shared definitions for the kernel_B stream feeder: default widths, a
// constant-evaluable log2 helper and the feeder FSM state encoding.
package kernel_b_stream_feeder_pkg;

  localparam int unsigned DATAW_DEF = 32;

  // Ceiling log2, usable in parameter/localparam elaboration.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/kernel_b_sync_fifo.sv
// Small synchronous FIFO whose output register always holds the current head.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push, pop  write / read strobes (ignored when full / empty)
//   din        write data
//   dout       registered copy of the head entry (0 after reset)
//   full       no free entry
//   empty      no valid entry
module kernel_b_sync_fifo
  import kernel_b_stream_feeder_pkg::*;
#(
  parameter int unsigned DATAW      = DATAW_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] din,
  output logic [DATAW-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATAW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_nxt;
  logic             do_push;
  logic             do_pop;
  logic             nxt_empty;
  logic [DATAW-1:0] head_nxt;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_nxt  = rd_ptr + PW'(do_pop);

  // Head after this cycle: the incoming word if the FIFO drains to it,
  // otherwise the already-stored entry at the advanced read pointer.
  assign nxt_empty = (rd_nxt == wr_ptr) && !do_push;
  assign head_nxt  = (rd_nxt == wr_ptr) ? din : mem[rd_nxt[AW-1:0]];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointers and head register; head holds when nothing moves or FIFO drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_nxt;
      if ((do_push || do_pop) && !nxt_empty) dout <= head_nxt;
    end
  end

endmodule

// File: rtl/kernel_b_stream_feeder.sv
// Feeds the stall-driven kernel_B pipeline from a valid/ready stream.
// Buffers input in a small FIFO, accepts exactly NKI words per run, issues
// them in order whenever the kernel can advance, then pulses done.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       run request, honoured only in IDLE
//   src_data/src_valid/src_ready  input stream
//   dst_stall   downstream sink back-pressure
//   krn_data    word presented to the kernel (FIFO head)
//   krn_stall   kernel hold; low means krn_data is consumed this cycle
//   busy        high while running
//   done        one-cycle pulse after the last item is issued
module kernel_b_stream_feeder
  import kernel_b_stream_feeder_pkg::*;
#(
  parameter int unsigned DATAW      = DATAW_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NKI        = 1024,
  parameter int unsigned CNTW       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DATAW-1:0] src_data,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic             dst_stall,
  output logic [DATAW-1:0] krn_data,
  output logic             krn_stall,
  output logic             busy,
  output logic             done
);

  localparam logic [CNTW-1:0] NKI_C  = CNTW'(NKI);
  localparam logic [CNTW-1:0] LAST_C = CNTW'(NKI - 1);

  state_t          state;
  logic [CNTW-1:0] acc_cnt;
  logic [CNTW-1:0] iss_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            run_c;
  logic            push;
  logic            pop;

  assign run_c     = (state == ST_RUN);
  assign src_ready = run_c & ~fifo_full & (acc_cnt < NKI_C);
  assign krn_stall = ~(run_c & ~fifo_empty & ~dst_stall);
  assign push      = src_valid & src_ready;
  assign pop       = ~krn_stall;

  kernel_b_sync_fifo #(
    .DATAW      (DATAW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (src_data),
    .dout  (krn_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Run-control FSM with item counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc_cnt <= '0;
      iss_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= ST_RUN;
            acc_cnt <= '0;
            iss_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (push && (acc_cnt < NKI_C)) acc_cnt <= acc_cnt + CNTW'(1);
          if (pop && (iss_cnt < NKI_C)) begin
            iss_cnt <= iss_cnt + CNTW'(1);
            // Last item leaves this cycle: finish the run.
            if (iss_cnt == LAST_C) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_b_stream_feeder.sv
// Scoreboard bench for kernel_b_stream_feeder (NKI=8, FIFO_DEPTH=4).
module tb_kernel_b_stream_feeder;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NKI   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic          dst_stall = 1'b0;
  logic [DW-1:0] krn_data;
  logic          krn_stall;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  kernel_b_stream_feeder #(
    .DATAW      (DW),
    .FIFO_DEPTH (DEPTH),
    .NKI        (NKI),
    .CNTW       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .dst_stall (dst_stall),
    .krn_data  (krn_data),
    .krn_stall (krn_stall),
    .busy      (busy),
    .done      (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected issue order: words the source model hands over, oldest first.
  logic [DW-1:0] sb_q [$];
  bit checks_en = 0;

  // Reference model of the run: phase flags, counts and buffer occupancy.
  bit m_run  = 0;
  bit m_done = 0;
  int m_acc  = 0;
  int m_iss  = 0;
  int m_occ  = 0;
  bit e_ready;
  bit e_stall;
  logic [DW-1:0] nxt_word = 32'd1;
  bit rand_data = 0;
  int n_issued = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed kernel word must be the oldest expected word;
  // a head that was stalled with data pending must not change.
  logic [DW-1:0] held;
  bit hold_chk = 0;
  always @(negedge clk) begin
    if (checks_en) begin
      if (hold_chk && krn_stall === 1'b1) check("krn_data_hold", krn_data, held);
      if (krn_stall === 1'b0) begin
        n_issued++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL issue_unexpected: got 0x%0h with nothing expected at %0t", krn_data, $time);
        end else begin
          check("krn_data_order", krn_data, sb_q.pop_front());
        end
      end
      hold_chk = (krn_stall === 1'b1) && (m_occ > 0) && !rst;
      held     = krn_data;
    end
  end

  // One clock of stimulus plus model step; entered and left at posedge+1.
  task automatic cycle(input bit v, input bit ds, input bit st, input bit r);
    src_valid = v;
    dst_stall = ds;
    start     = st;
    rst       = r;
    src_data  = nxt_word;
    @(negedge clk);
    e_ready = m_run && (m_occ < DEPTH) && (m_acc < NKI);
    e_stall = !(m_run && (m_occ > 0) && !ds);
    if (checks_en) begin
      check("src_ready", 32'(src_ready), 32'(e_ready));
      check("krn_stall", 32'(krn_stall), 32'(e_stall));
      check("busy", 32'(busy), 32'(m_run));
      check("done", 32'(done), 32'(m_done));
    end
    if (v && e_ready) sb_q.push_back(nxt_word);
    @(posedge clk);
    if (r) begin
      m_run = 0; m_done = 0; m_acc = 0; m_iss = 0; m_occ = 0;
      sb_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1; m_acc = 0; m_iss = 0;
      end
    end else begin
      if (v && e_ready) begin
        m_acc++;
        m_occ++;
        nxt_word = rand_data ? $urandom : nxt_word + 32'd1;
      end
      if (!e_stall) begin
        m_occ--;
        m_iss++;
        if (m_iss == NKI) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end
    #1;
  endtask

  // mode 0 stream, 1 starved 1,0,0,1, 2 random, 3 back-pressure window,
  // 4 stream with a start pulse mid-run.
  task automatic run_until_done(input int mode);
    bit v, ds, st, finished;
    n_issued = 0;
    finished = 0;
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 300; i++) begin
      v = 1; ds = 0; st = 0;
      case (mode)
        1: v = ((i % 4) == 0) || ((i % 4) == 3);
        2: begin
          v  = ($urandom % 4) != 0;
          ds = ($urandom % 3) == 0;
          st = ($urandom % 8) == 0;
        end
        3: ds = (i >= 3) && (i < 9);
        4: st = (i == 3);
        default: ;
      endcase
      cycle(v, ds, st, 0);
      if (m_done) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_timeout: mode %0d never completed", mode);
    end
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("items_issued", 32'(n_issued), 32'(NKI));
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cycle(0, 0, 0, 1);
    checks_en = 1;
    cycle(0, 0, 0, 1);
    check("reset_krn_data", krn_data, 32'd0);

    // Streaming 1..8, also guards against accepting a 9th word.
    nxt_word = 32'd1;
    run_until_done(0);
    // Back-pressure window fills the buffer, then drains in order.
    run_until_done(3);
    // Starved source.
    run_until_done(1);
    // Start pulse during RUN must not restart the counts.
    run_until_done(4);

    // Reset mid-run after 5 pushes.
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check("midrun_reset_krn_data", krn_data, 32'd0);
    check("midrun_reset_krn_stall", 32'(krn_stall), 32'd1);
    check("midrun_reset_src_ready", 32'(src_ready), 32'd0);
    check("midrun_reset_busy", 32'(busy), 32'd0);
    run_until_done(0);

    // start together with rst: reset wins, stays idle.
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Randomized runs.
    rand_data = 1;
    nxt_word  = $urandom;
    for (int k = 0; k < 6; k++) run_until_done(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
